// File: rtl/lighting_pkg.sv
// Shared constants and helpers for the home-lighting controller.
package lighting_pkg;

   // One-hot time-of-day codes from the time/sensor front end
   localparam logic [3:0] TC_IDLE    = 4'b0000;
   localparam logic [3:0] TC_MORNING = 4'b0001;
   localparam logic [3:0] TC_NOON    = 4'b0010;
   localparam logic [3:0] TC_EVENING = 4'b0100;
   localparam logic [3:0] TC_NIGHT   = 4'b1000;

   localparam logic [3:0] SHADE_OPEN   = 4'd15;
   localparam logic [3:0] SHADE_CLOSED = 4'd0;

   localparam int NUM_LAMPS = 16;

   // Unsigned 4-bit minimum; equal operands return that value
   function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
      return (a < b) ? a : b;
   endfunction

   // Move cur one step toward tgt, or hold when already there
   function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
      if (cur < tgt)      return cur + 4'd1;
      else if (cur > tgt) return cur - 4'd1;
      else                return cur;
   endfunction

endpackage

// File: rtl/lamp_thermo_decoder.sv
// Purely combinational 4-bit count to 16-bit thermometer code:
// bit i is set iff i < count, so bit 15 is never set.
module lamp_thermo_decoder
   import lighting_pkg::*;
(
   input  logic [3:0]           count,
   output logic [NUM_LAMPS-1:0] therm
);

   // Light every lamp position below the requested count
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
      therm = '0;
      for (int i = 0; i < NUM_LAMPS - 1; i++) begin
         therm[i] = (count > 4'(i));
      end
   end

endmodule

// File: rtl/lighting_system.sv
// Registered home-lighting controller: time-of-day code, user lamp request
// and room length in; shade level, lamp count and lamp vector out, one
// cycle later.
// Optional build macro LIGHTING_SYSTEM_RAMP_EN: shade and lamp count step
// toward their targets by at most one per clock instead of jumping.
module lighting_system
   import lighting_pkg::*;
#(
   parameter logic [3:0] NOON_SHADE  = 4'd7,
   parameter int         NIGHT_SHIFT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           tcode,
   input  logic [3:0]           ulight,
   input  logic [3:0]           lenght,
   output logic [3:0]           wshade,
   output logic [3:0]           lightnum,
   output logic [NUM_LAMPS-1:0] lightstate
);

   logic [3:0] shade_tgt;
   logic [3:0] num_tgt;

   // Decode the time code into shade and lamp-count targets; unknown codes act as idle
   always_comb begin
      shade_tgt = SHADE_CLOSED;
      num_tgt   = 4'd0;
      case (tcode)
         TC_MORNING: shade_tgt = SHADE_OPEN;
         TC_NOON:    shade_tgt = NOON_SHADE;
         TC_EVENING: num_tgt   = min4(ulight, lenght);
         TC_NIGHT:   num_tgt   = min4(ulight, lenght >> NIGHT_SHIFT);
         default: ;
      endcase
   end

   // Output registers: jump to target, or ramp by one when the ramp build is enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wshade   <= SHADE_CLOSED;
         lightnum <= 4'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
`ifdef LIGHTING_SYSTEM_RAMP_EN
         wshade   <= step_toward(wshade, shade_tgt);
         lightnum <= step_toward(lightnum, num_tgt);
`else
         wshade   <= shade_tgt;
         lightnum <= num_tgt;
`endif
      end
   end

   // Lamp vector comes from the registered count so it always matches lightnum
   lamp_thermo_decoder u_thermo (
      .count (lightnum),
      .therm (lightstate)
   );

endmodule

// File: tb/tb_lighting_system.sv
// Directed self-checking bench for lighting_system. Builds with or without
// LIGHTING_SYSTEM_RAMP_EN; the ramp scenario replaces the jump scenarios.
module tb_lighting_system;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  tcode, ulight, lenght;
   logic [3:0]  wshade, lightnum;
   logic [15:0] lightstate;

   int n_cmp = 0;
   int n_err = 0;

   lighting_system dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tcode      (tcode),
      .ulight     (ulight),
      .lenght     (lenght),
      .wshade     (wshade),
      .lightnum   (lightnum),
      .lightstate (lightstate)
   );

   always #5 clk = ~clk;

   // Present inputs, let one rising edge capture them, sample 1 time unit later
   task automatic apply(input logic [3:0] t, input logic [3:0] u, input logic [3:0] l);
      tcode = t; ulight = u; lenght = l;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tcode = 4'b0000; ulight = 4'd0; lenght = 4'd0;
      #3;
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_initial: got %h/%h/%h want 0/0/0000", wshade, lightnum, lightstate);
      end
      @(negedge clk); rst_n = 1'b1;
      // Drive outputs non-zero, then pull reset between clock edges
      apply(4'b0100, 4'd12, 4'd9);
      apply(4'b0001, 4'd12, 4'd9);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_async: got %h/%h/%h want 0/0/0000", wshade, lightnum, lightstate);
      end
      @(negedge clk);
      tcode = 4'b0000;
      rst_n = 1'b1;
      apply(4'b0000, 4'd12, 4'd9);
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_release_idle: got %h/%h/%h want 0/0/0000", wshade, lightnum, lightstate);
      end
   endtask

`ifndef LIGHTING_SYSTEM_RAMP_EN
   typedef struct {
      logic [3:0]  t, u, l;
      logic [3:0]  ws, ln;
      logic [15:0] ls;
   } vec_t;

   // Walk a table of {inputs, expected outputs}, one vector per clock
   task automatic run_table(input string name, input vec_t v[$]);
      foreach (v[k]) begin
         apply(v[k].t, v[k].u, v[k].l);
         n_cmp++;
         if ({wshade, lightnum, lightstate} !== {v[k].ws, v[k].ln, v[k].ls}) begin
            n_err++;
            $display("FAIL %s[%0d] t=%b u=%0d l=%0d: got %0d/%0d/%h want %0d/%0d/%h",
                     name, k, v[k].t, v[k].u, v[k].l, wshade, lightnum, lightstate,
                     v[k].ws, v[k].ln, v[k].ls);
         end
      end
   endtask

   task automatic test_shade();
      vec_t v[$];
      v.push_back('{4'b0001, 4'd12, 4'd9, 4'd15, 4'd0, 16'h0000});
      v.push_back('{4'b0010, 4'd12, 4'd9, 4'd7,  4'd0, 16'h0000});
      run_table("shade", v);
   endtask

   task automatic test_evening();
      vec_t v[$];
      v.push_back('{4'b0100, 4'd12, 4'd9,  4'd0, 4'd9,  16'h01FF});
      v.push_back('{4'b0100, 4'd3,  4'd9,  4'd0, 4'd3,  16'h0007});
      v.push_back('{4'b0100, 4'd3,  4'd14, 4'd0, 4'd3,  16'h0007});
      v.push_back('{4'b0100, 4'd9,  4'd9,  4'd0, 4'd9,  16'h01FF});
      v.push_back('{4'b0100, 4'd0,  4'd9,  4'd0, 4'd0,  16'h0000});
      v.push_back('{4'b0100, 4'd15, 4'd15, 4'd0, 4'd15, 16'h7FFF});
      run_table("evening", v);
   endtask

   task automatic test_night();
      vec_t v[$];
      v.push_back('{4'b1000, 4'd6,  4'd9,  4'd0, 4'd4, 16'h000F});
      v.push_back('{4'b1000, 4'd14, 4'd9,  4'd0, 4'd4, 16'h000F});
      v.push_back('{4'b1000, 4'd2,  4'd9,  4'd0, 4'd2, 16'h0003});
      v.push_back('{4'b1000, 4'd15, 4'd15, 4'd0, 4'd7, 16'h007F});
      v.push_back('{4'b1000, 4'd5,  4'd1,  4'd0, 4'd0, 16'h0000});
      run_table("night", v);
   endtask

   task automatic test_illegal();
      vec_t v[$];
      v.push_back('{4'b0100, 4'd15, 4'd15, 4'd0, 4'd15, 16'h7FFF});
      v.push_back('{4'b0101, 4'd12, 4'd9,  4'd0, 4'd0,  16'h0000});
      v.push_back('{4'b0001, 4'd12, 4'd9,  4'd15, 4'd0, 16'h0000});
      v.push_back('{4'b1111, 4'd12, 4'd9,  4'd0, 4'd0,  16'h0000});
      v.push_back('{4'b0011, 4'd12, 4'd9,  4'd0, 4'd0,  16'h0000});
      v.push_back('{4'b0000, 4'd12, 4'd9,  4'd0, 4'd0,  16'h0000});
      run_table("illegal", v);
   endtask

   // Inputs change every cycle; outputs must hold until the next edge
   task automatic test_back_to_back();
      apply(4'b0100, 4'd5, 4'd9);
      tcode = 4'b0010; ulight = 4'd12; lenght = 4'd9;
      #2;
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== {4'd0, 4'd5, 16'h001F}) begin
         n_err++;
         $display("FAIL latency_hold: got %0d/%0d/%h want 0/5/001F", wshade, lightnum, lightstate);
      end
      apply(4'b0010, 4'd12, 4'd9);
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== {4'd7, 4'd0, 16'h0000}) begin
         n_err++;
         $display("FAIL b2b_noon: got %0d/%0d/%h want 7/0/0000", wshade, lightnum, lightstate);
      end
      apply(4'b1000, 4'd12, 4'd12);
      n_cmp++;
      if ({wshade, lightnum, lightstate} !== {4'd0, 4'd6, 16'h003F}) begin
         n_err++;
         $display("FAIL b2b_night: got %0d/%0d/%h want 0/6/003F", wshade, lightnum, lightstate);
      end
   endtask
`else
   // Ramp up 0..9 on evening, then morning ramps lamps down and shade open
   task automatic test_ramp();
      int exp_ln, exp_ws;
      apply(4'b0000, 4'd0, 4'd0);
      for (int k = 1; k <= 10; k++) begin
         apply(4'b0100, 4'd9, 4'd9);
         exp_ln = (k > 9) ? 9 : k;
         n_cmp++;
         if ({wshade, lightnum, lightstate} !== {4'd0, 4'(exp_ln), 16'((32'd1 << exp_ln) - 1)}) begin
            n_err++;
            $display("FAIL ramp_up[%0d]: got %0d/%0d/%h want 0/%0d", k, wshade, lightnum, lightstate, exp_ln);
         end
      end
      for (int k = 1; k <= 16; k++) begin
         apply(4'b0001, 4'd9, 4'd9);
         exp_ln = (k >= 9) ? 0 : 9 - k;
         exp_ws = (k > 15) ? 15 : k;
         n_cmp++;
         if ({wshade, lightnum, lightstate} !== {4'(exp_ws), 4'(exp_ln), 16'((32'd1 << exp_ln) - 1)}) begin
            n_err++;
            $display("FAIL ramp_down[%0d]: got %0d/%0d/%h want %0d/%0d", k, wshade, lightnum, lightstate, exp_ws, exp_ln);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef LIGHTING_SYSTEM_RAMP_EN
      test_ramp();
`else
      test_shade();
      test_evening();
      test_night();
      test_illegal();
      test_back_to_back();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
